// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: general-purpose register file feeding the ALU operands.
// Two combinational read ports (Qa -> ALU X, Qb -> ALU Y) and one synchronous
// write port (ALU result or load data at writeback). Register 0 reads as zero
// and has no storage. With BYPASS=1, a write in progress is forwarded to any
// read port that addresses the same register in the same cycle.
//
// Ports:
//   Clk  in   clock, all state changes on rising edge
//   Rst  in   synchronous active-high reset; also forces Qa/Qb to zero
//   Ra1  in   [AW]  read address, port A
//   Ra2  in   [AW]  read address, port B
//   Wa   in   [AW]  write address
//   We   in   write enable
//   D    in   [DW]  write data
//   Qa   out  [DW]  read data, port A
//   Qb   out  [DW]  read data, port B
module reg_file_2r1w #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned BYPASS = 1
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [AW-1:0] Ra1,
  input  logic [AW-1:0] Ra2,
  input  logic [AW-1:0] Wa,
  input  logic          We,
  input  logic [DW-1:0] D,
  output logic [DW-1:0] Qa,
  output logic [DW-1:0] Qb
);

  localparam int unsigned DEPTH = 2 ** AW;

  // Entry 0 is deliberately absent; reads of address 0 are decoded to zero.
  logic [DW-1:0] regs [1:DEPTH-1];

  logic wr_ok;
  logic byp_a;
  logic byp_b;

  assign wr_ok = We && (Wa != '0);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        regs[i[AW-1:0]] <= '0;
      end
    end else if (wr_ok) begin
      regs[Wa] <= D;
    end
  end

  // wr_ok already excludes address 0, so bypass can never hit register 0.
  always_comb begin
    byp_a = 1'b0;
    byp_b = 1'b0;
    if (BYPASS != 0) begin
      byp_a = wr_ok && (Wa == Ra1);
      byp_b = wr_ok && (Wa == Ra2);
    end
  end

  always_comb begin
    Qa = '0;
    if (Rst) begin
      Qa = '0;
    end else if (byp_a) begin
      Qa = D;
    end else if (Ra1 != '0) begin
      Qa = regs[Ra1];
    end
  end

  always_comb begin
    Qb = '0;
    if (Rst) begin
      Qb = '0;
    end else if (byp_b) begin
      Qb = D;
    end else if (Ra2 != '0) begin
      Qb = regs[Ra2];
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
module tb_reg_file_2r1w;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          Clk;
  logic          Rst;
  logic [AW-1:0] Ra1;
  logic [AW-1:0] Ra2;
  logic [AW-1:0] Wa;
  logic          We;
  logic [DW-1:0] D;
  logic [DW-1:0] qa;
  logic [DW-1:0] qb;
  logic [DW-1:0] qa_nb;
  logic [DW-1:0] qb_nb;

  int compared;
  int mismatched;

  reg_file_2r1w #(.DW(DW), .AW(AW), .BYPASS(1)) dut (
    .Clk(Clk), .Rst(Rst), .Ra1(Ra1), .Ra2(Ra2), .Wa(Wa), .We(We), .D(D),
    .Qa(qa), .Qb(qb)
  );

  reg_file_2r1w #(.DW(DW), .AW(AW), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Rst(Rst), .Ra1(Ra1), .Ra2(Ra2), .Wa(Wa), .We(We), .D(D),
    .Qa(qa_nb), .Qb(qb_nb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance past the next rising edge; inputs change and outputs are sampled
  // 1 ns after the edge, well away from it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    We = 1'b1; Wa = a; D = d;
    tick();
    We = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; We = 1'b0; Wa = '0; D = '0; Ra1 = '0; Ra2 = '0;
    tick();
    tick();
    Rst = 1'b0;
    wr(5'd5, 32'hDEADBEEF);
    Ra1 = 5'd5; #1;
    compared++;
    if (qa !== 32'hDEADBEEF) begin
      mismatched++; $display("FAIL reset_pre_write qa=%h exp=%h", qa, 32'hDEADBEEF);
    end
    // Outputs forced to zero while Rst is high, any address.
    Rst = 1'b1; Ra1 = 5'd5; Ra2 = 5'd31; #1;
    compared++;
    if (qa !== '0 || qb !== '0 || qa_nb !== '0) begin
      mismatched++; $display("FAIL reset_force qa=%h qb=%h qa_nb=%h exp=0", qa, qb, qa_nb);
    end
    tick();
    Rst = 1'b0; #1;
    compared++;
    if (qa !== '0 || qa_nb !== '0) begin
      mismatched++; $display("FAIL reset_clear qa=%h qa_nb=%h exp=0", qa, qa_nb);
    end
  endtask

  task automatic test_write_read();
    wr(5'd3, 32'h00000007);
    wr(5'd4, 32'hFFFFFFF9);
    Ra1 = 5'd3; Ra2 = 5'd4; #1;
    compared++;
    if (qa !== 32'h00000007 || qb !== 32'hFFFFFFF9) begin
      mismatched++; $display("FAIL write_read qa=%h qb=%h exp=00000007/fffffff9", qa, qb);
    end
    // ALU add of the two operands must give zero.
    compared++;
    if ((qa + qb) !== 32'h0) begin
      mismatched++; $display("FAIL alu_add_zero sum=%h exp=0", qa + qb);
    end
    Ra1 = 5'd4; Ra2 = 5'd4; #1;
    compared++;
    if (qa !== 32'hFFFFFFF9 || qb !== 32'hFFFFFFF9) begin
      mismatched++; $display("FAIL same_addr qa=%h qb=%h exp=fffffff9", qa, qb);
    end
  endtask

  task automatic test_reg0();
    We = 1'b1; Wa = 5'd0; D = 32'h12345678; Ra1 = 5'd0; Ra2 = 5'd0; #1;
    compared++;
    if (qa !== '0 || qb !== '0) begin
      mismatched++; $display("FAIL reg0_same_cycle qa=%h qb=%h exp=0", qa, qb);
    end
    tick();
    We = 1'b0; #1;
    compared++;
    if (qa !== '0 || qa_nb !== '0) begin
      mismatched++; $display("FAIL reg0_after qa=%h qa_nb=%h exp=0", qa, qa_nb);
    end
    Ra2 = 5'd3; #1;
    compared++;
    if (qb !== 32'h00000007) begin
      mismatched++; $display("FAIL reg0_no_alias qb=%h exp=00000007", qb);
    end
  endtask

  task automatic test_bypass();
    wr(5'd7, 32'h11111111);
    We = 1'b1; Wa = 5'd7; D = 32'h22222222; Ra1 = 5'd7; Ra2 = 5'd7; #1;
    compared++;
    if (qa !== 32'h22222222 || qb !== 32'h22222222) begin
      mismatched++; $display("FAIL bypass_before qa=%h qb=%h exp=22222222", qa, qb);
    end
    compared++;
    if (qa_nb !== 32'h11111111 || qb_nb !== 32'h11111111) begin
      mismatched++; $display("FAIL nobypass_before qa=%h qb=%h exp=11111111", qa_nb, qb_nb);
    end
    tick();
    We = 1'b0; #1;
    compared++;
    if (qa !== 32'h22222222 || qb_nb !== 32'h22222222) begin
      mismatched++; $display("FAIL bypass_after qa=%h qb_nb=%h exp=22222222", qa, qb_nb);
    end
  endtask

  task automatic test_independent();
    We = 1'b1; Wa = 5'd10; D = 32'hA5A5A5A5; Ra1 = 5'd3; Ra2 = 5'd10; #1;
    compared++;
    if (qa !== 32'h00000007 || qb !== 32'hA5A5A5A5 || qa_nb !== 32'h00000007 || qb_nb !== '0) begin
      mismatched++;
      $display("FAIL independent qa=%h qb=%h qa_nb=%h qb_nb=%h exp=7/a5a5a5a5/7/0", qa, qb, qa_nb, qb_nb);
    end
    tick();
    We = 1'b0; #1;
    compared++;
    if (qb_nb !== 32'hA5A5A5A5 || qa !== 32'h00000007) begin
      mismatched++; $display("FAIL independent_after qb_nb=%h qa=%h exp=a5a5a5a5/7", qb_nb, qa);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i < 32; i++) begin
      wr(i[AW-1:0], 32'h01010101 * i);
    end
    for (int i = 1; i < 32; i += 5) begin
      Ra1 = i[AW-1:0]; Ra2 = 5'(32 - i); #1;
      compared++;
      if (qa !== 32'h01010101 * i || qb_nb !== 32'h01010101 * (32 - i)) begin
        mismatched++;
        $display("FAIL back_to_back i=%0d qa=%h qb_nb=%h exp=%h/%h", i, qa, qb_nb,
                 32'h01010101 * i, 32'h01010101 * (32 - i));
      end
    end
    Ra1 = 5'd31; #1;
    compared++;
    if (qa !== 32'h1F1F1F1F) begin
      mismatched++; $display("FAIL top_entry qa=%h exp=1f1f1f1f", qa);
    end
  endtask

  task automatic test_reset_beats_write();
    Rst = 1'b1; We = 1'b1; Wa = 5'd9; D = 32'hAAAAAAAA; Ra1 = 5'd9; Ra2 = 5'd9; #1;
    compared++;
    if (qa !== '0 || qb !== '0) begin
      mismatched++; $display("FAIL rst_no_bypass qa=%h qb=%h exp=0", qa, qb);
    end
    tick();
    Rst = 1'b0; We = 1'b0; #1;
    compared++;
    if (qb !== '0 || qb_nb !== '0) begin
      mismatched++; $display("FAIL rst_beats_write qb=%h qb_nb=%h exp=0", qb, qb_nb);
    end
    Ra1 = 5'd31; Ra2 = 5'd7; #1;
    compared++;
    if (qa !== '0 || qb !== '0) begin
      mismatched++; $display("FAIL rst_full_clear qa=%h qb=%h exp=0", qa, qb);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_write_read();
    test_reg0();
    test_bypass();
    test_independent();
    test_back_to_back();
    test_reset_beats_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
